// File: rtl/vga_pattern_gen.sv
// Pixel stage behind the VGA timing generator: registered RGB332 test patterns
// (vertical/horizontal/scrolling stripes, bouncing box) with syncs re-aligned to colour.
module vga_pattern_gen #(
  parameter int HBP          = 245,
  parameter int VBP          = 50,
  parameter int H_ACTIVE     = 1023,
  parameter int V_ACTIVE     = 781,
  parameter int STRIPE_SHIFT = 7,
  parameter int SPEED        = 2,
  parameter int BOX_SIZE     = 64,
  parameter int STEP         = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        vidon,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);

  logic [1:0]  mode_q;
  logic [10:0] scroll;
  logic [10:0] bx, by;
  logic        dx_neg, dy_neg;
  logic        vs_prev;
  logic        tick;
  logic [10:0] x, y, sx;
  logic [11:0] bx_step, by_step;
  logic        in_box;
  logic [7:0]  colour;

  function automatic logic [7:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 8'h00;
      3'd1:    palette = 8'h03;
      3'd2:    palette = 8'h1C;
      3'd3:    palette = 8'h1F;
      3'd4:    palette = 8'hE0;
      3'd5:    palette = 8'hE3;
      3'd6:    palette = 8'hFC;
      default: palette = 8'hFF;
    endcase
  endfunction

  // Returns {direction_negative, position} after one frame of bouncing.
  function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic neg,
                                            input logic [10:0] lim);
    logic [11:0] res;
    res = {neg, pos};
    if (!neg) begin
      if ({1'b0, pos} + 12'(STEP) >= {1'b0, lim}) res = {1'b1, lim};
      else                                       res = {1'b0, pos + 11'(STEP)};
    end else begin
      if (pos <= 11'(STEP)) res = {1'b0, 11'd0};
      else                  res = {1'b1, pos - 11'(STEP)};
    end
    return res;
  endfunction

  assign tick    = vs_prev & ~vsync_in;
  assign x       = hc - 11'(HBP);
  assign y       = vc - 11'(VBP);
  assign sx      = x + scroll;
  assign bx_step = step_axis(bx, dx_neg, X_MAX);
  assign by_step = step_axis(by, dy_neg, Y_MAX);

  // Widened compares keep bx + BOX_SIZE from wrapping for any parameter choice.
  assign in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + 12'(BOX_SIZE)) &&
                  ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + 12'(BOX_SIZE));

  always_comb begin
    colour = 8'h00;
    if (vidon) begin
      case (mode_q)
        2'd0:    colour = palette(3'(x >> STRIPE_SHIFT));
        2'd1:    colour = palette(3'(y >> STRIPE_SHIFT));
        2'd2:    colour = palette(3'(sx >> STRIPE_SHIFT));
        default: colour = in_box ? 8'hFF : 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
      vs_prev    <= 1'b0;
      mode_q     <= 2'd0;
      scroll     <= '0;
      bx         <= '0;
      by         <= '0;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
    end else begin
      red        <= colour[7:5];
      green      <= colour[4:2];
      blue       <= colour[1:0];
      hsync      <= hsync_in;
      vsync      <= vsync_in;
      frame_tick <= tick;
      vs_prev    <= vsync_in;
      if (tick) begin
        mode_q <= mode;
        scroll <= scroll + 11'(SPEED);
        bx     <= bx_step[10:0];
        dx_neg <= bx_step[11];
        by     <= by_step[10:0];
        dy_neg <= by_step[11];
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed corner cases plus randomized traffic, every
// cycle compared against an integer-arithmetic frame model.
module tb_vga_pattern_gen;

  localparam int HBP = 245, VBP = 50, H_ACTIVE = 1023, V_ACTIVE = 781;
  localparam int SS = 7, SPEED = 2, BOX = 64, STEP = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [10:0] hc = '0, vc = '0;
  logic        vidon = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        hsync, vsync, frame_tick;
  logic [7:0]  rgb;

  int n_cmp = 0, n_bad = 0;

  int m_mode, m_scroll, m_bx, m_by, m_dx, m_dy;
  bit m_vs_prev;
  int e_rgb;
  bit e_hs, e_vs, e_tick;

  vga_pattern_gen dut (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pal(input int i);
    case (i & 7)
      0: return 8'h00;
      1: return 8'h03;
      2: return 8'h1C;
      3: return 8'h1F;
      4: return 8'hE0;
      5: return 8'hE3;
      6: return 8'hFC;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_scroll = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_vs_prev = 0;
    e_rgb = 0; e_hs = 1; e_vs = 1; e_tick = 0;
  endtask

  task automatic bounce(inout int pos, inout int dir, input int lim);
    if (dir > 0) begin
      if (pos + STEP >= lim) begin pos = lim; dir = -1; end
      else pos = pos + STEP;
    end else begin
      if (pos <= STEP) begin pos = 0; dir = 1; end
      else pos = pos - STEP;
    end
  endtask

  function automatic int ref_colour(input int x, input int y, input bit v);
    if (!v) return 0;
    case (m_mode)
      0: return pal(x / (1 << SS));
      1: return pal(y / (1 << SS));
      2: return pal(((x + m_scroll) % 2048) / (1 << SS));
      default: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Expected outputs for the edge just taken; then the frame state advances on a tick.
  task automatic model_edge();
    int x, y;
    bit t;
    if (clr) begin
      model_reset();
      return;
    end
    x = (int'(hc) - HBP + 2048) % 2048;
    y = (int'(vc) - VBP + 2048) % 2048;
    e_rgb  = ref_colour(x, y, vidon);
    e_hs   = hsync_in;
    e_vs   = vsync_in;
    t      = m_vs_prev && !vsync_in;
    e_tick = t;
    if (t) begin
      m_mode   = int'(mode);
      m_scroll = (m_scroll + SPEED) % 2048;
      bounce(m_bx, m_dx, H_ACTIVE - BOX);
      bounce(m_by, m_dy, V_ACTIVE - BOX);
    end
    m_vs_prev = vsync_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("rgb", rgb, e_rgb);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("frame_tick", frame_tick, e_tick);
  endtask

  task automatic do_tick();
    vsync_in = 1'b1; cyc();
    vsync_in = 1'b0; cyc();
    chk("tick_pulse", frame_tick, 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input int exp);
    hc = 11'(HBP + x); vc = 11'(VBP + y); vidon = 1'b1;
    cyc();
    chk(tag, rgb, exp);
  endtask

  initial begin
    model_reset();

    // reset holds outputs even while inputs toggle
    repeat (2) cyc();
    hsync_in = 1'b0; vsync_in = 1'b0; vidon = 1'b1; hc = 11'(HBP + 900);
    cyc();
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    clr = 1'b0;
    cyc();
    chk("no_tick_after_clr", frame_tick, 0);
    hsync_in = 1'b1;
    do_tick();

    // mode 0 stripes
    pulse_clr();
    probe("m0_x0", 0, 0, 8'h00);
    probe("m0_x128", 128, 0, 8'h03);
    probe("m0_x900", 900, 0, 8'hFF);
    vidon = 1'b0; cyc();
    chk("m0_blank", rgb, 8'h00);

    // sync alignment
    hsync_in = 1'b0; vidon = 1'b1; cyc();
    chk("align_hs", hsync, 0);
    chk("align_rgb", rgb, 8'hFF);
    hsync_in = 1'b1; vsync_in = 1'b1; cyc();
    chk("align_hs_back", hsync, 1);
    chk("align_vs", vsync, 1);

    // mode 2 scroll
    pulse_clr();
    mode = 2'd2;
    repeat (3) do_tick();
    probe("m2_x122", 122, 0, 8'h03);
    probe("m2_x121", 121, 0, 8'h00);

    // mode 3 bounce
    pulse_clr();
    mode = 2'd3;
    for (int i = 1; i <= 241; i++) begin
      do_tick();
      if (i == 180) begin
        probe("by180_in", 720, 717, 8'hFF);
        probe("by180_out", 720, 716, 8'h00);
      end
      if (i == 181) begin
        probe("by181_in", 724, 713, 8'hFF);
        probe("by181_out", 724, 712, 8'h00);
      end
      if (i == 239) begin
        probe("bx239_in", 956, 500, 8'hFF);
        probe("bx239_out", 955, 500, 8'h00);
      end
      if (i == 240) begin
        probe("bx240_in", 959, 500, 8'hFF);
        probe("bx240_out", 958, 500, 8'h00);
      end
      if (i == 241) begin
        probe("bx241_in", 955, 500, 8'hFF);
        probe("bx241_out", 954, 500, 8'h00);
      end
    end

    // mode change mid-frame, then clr mid-frame
    pulse_clr();
    mode = 2'd0;
    probe("mc_stripe", 900, 10, 8'hFF);
    mode = 2'd3;
    probe("mc_still_stripe", 900, 10, 8'hFF);
    do_tick();
    probe("mc_box_out", 900, 10, 8'h00);
    probe("mc_box_in", 10, 10, 8'hFF);
    #2 clr = 1'b1;
    model_reset();
    #1;
    chk("clr_async_rgb", rgb, 8'h00);
    cyc();
    clr = 1'b0;
    mode = 2'd2;
    do_tick();
    probe("clr_scroll_in", 126, 0, 8'h03);
    probe("clr_scroll_out", 125, 0, 8'h00);
    mode = 2'd3;
    do_tick();
    probe("clr_bx_in", 8, 8, 8'hFF);
    probe("clr_bx_out", 7, 8, 8'h00);

    // randomized traffic against the model
    pulse_clr();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if (m_mode == 3 && $urandom_range(0, 1) == 1) begin
        hc = 11'(HBP + m_bx + int'($urandom_range(0, 72)) - 4);
        vc = 11'(VBP + m_by + int'($urandom_range(0, 72)) - 4);
      end else begin
        hc = 11'($urandom_range(0, 1500));
        vc = 11'($urandom_range(0, 900));
      end
      vidon    = ($urandom_range(0, 4) != 0);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) clr = 1'b1;
      else clr = 1'b0;
      cyc();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
